// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-word controller for a DDS phase accumulator.
// Two debounced active-low keys step a manual frequency word up/down within
// [FWORD_MIN, FWORD_MAX]; sweep_en switches to an automatic sawtooth or
// triangle sweep. fword is always a register output and stays within bounds.
module dds_sweep_ctrl #(
    parameter int                FW_W       = 32,
    parameter logic [FW_W-1:0]   FWORD_INIT = 32'd300,
    parameter logic [FW_W-1:0]   FWORD_STEP = 32'd100,
    parameter logic [FW_W-1:0]   FWORD_MIN  = 32'd100,
    parameter logic [FW_W-1:0]   FWORD_MAX  = 32'd100000,
    parameter logic [FW_W-1:0]   SWEEP_STEP = 32'd50,
    parameter int                SWEEP_DIV  = 24000,
    parameter int                DEB_CYCLES = 240000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_plus,
    input  logic            key_down,
    input  logic            sweep_en,
    input  logic            sweep_tri,
    output logic [FW_W-1:0] fword,
    output logic            fword_upd,
    output logic            sweep_active,
    output logic            LED1
);

    localparam int TICK_W = (SWEEP_DIV  > 1) ? $clog2(SWEEP_DIV)  : 1;
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    // Bounds widened by one bit so sums and differences never wrap.
    localparam logic [FW_W:0] MIN_X   = {1'b0, FWORD_MIN};
    localparam logic [FW_W:0] MAX_X   = {1'b0, FWORD_MAX};
    localparam logic [FW_W:0] STEP_X  = {1'b0, FWORD_STEP};
    localparam logic [FW_W:0] SSTEP_X = {1'b0, SWEEP_STEP};

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        SWEEP_UP   = 2'd1,
        SWEEP_DOWN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Key conditioning: bit 0 = plus key, bit 1 = down key.
    // ------------------------------------------------------------------
    logic [1:0] key_raw;
    logic [1:0] press;

    assign key_raw = {key_down, key_plus};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             armed_reg;
            logic             press_reg;
            logic [DEB_W-1:0] cnt_reg;
            logic             target;
            logic             settled;

            // Until a key has been seen stably released after reset it is
            // not armed, so a key held through reset never yields a press.
            assign target  = armed_reg ? ~deb_reg : 1'b1;
            assign settled = (cnt_reg == DEB_W'(DEB_CYCLES - 1));

            // Synchronise, count consecutive samples at the target level, and
            // emit a one-cycle press on the accepted released->pressed edge.
            // The synchroniser resets to the pressed level so a held key
            // cannot look released for the first couple of cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b1;
                    armed_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= key_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg != target) begin
                        cnt_reg <= '0;
                    end else if (settled) begin
                        cnt_reg <= '0;
                        if (armed_reg) begin
                            deb_reg   <= sync2_reg;
                            press_reg <= ~sync2_reg;
                        end else begin
                            armed_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Manual frequency word
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [FW_W-1:0] man_fw_reg, man_fw_next;
    logic [FW_W-1:0] fword_reg, fword_next;
    logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic            led_reg, led_next;
    logic            upd_reg;
    logic            tick;
    logic            man_up_over;
    logic            man_dn_under;
    logic            sw_up_over;
    logic            sw_dn_under;

    assign man_up_over  = ({1'b0, man_fw_reg} + STEP_X) > MAX_X;
    assign man_dn_under = {1'b0, man_fw_reg} < (MIN_X + STEP_X);
    assign sw_up_over   = ({1'b0, fword_reg} + SSTEP_X) > MAX_X;
    assign sw_dn_under  = {1'b0, fword_reg} < (MIN_X + SSTEP_X);
    assign tick         = (tick_cnt_reg == TICK_W'(SWEEP_DIV - 1));

    // Clamped manual step; keys only act in MANUAL and cancel each other.
    always_comb begin
        man_fw_next = man_fw_reg;
        if (state_reg == MANUAL) begin
            if (press[0] && !press[1]) begin
                man_fw_next = man_up_over ? FWORD_MAX : man_fw_reg + FWORD_STEP;
            end else if (press[1] && !press[0]) begin
                man_fw_next = man_dn_under ? FWORD_MIN : man_fw_reg - FWORD_STEP;
            end
        end
    end

    // Sweep FSM next state, next frequency word, tick counter and LED toggle.
    always_comb begin
        state_next    = state_reg;
        fword_next    = fword_reg;
        tick_cnt_next = tick_cnt_reg;
        led_next      = led_reg;
        case (state_reg)
            MANUAL: begin
                if (sweep_en) begin
                    state_next    = SWEEP_UP;
                    fword_next    = FWORD_MIN;
                    tick_cnt_next = '0;
                end else begin
                    fword_next = man_fw_reg;
                end
            end
            SWEEP_UP: begin
                if (!sweep_en) begin
                    state_next = MANUAL;
                    fword_next = man_fw_reg;
                end else begin
                    tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
                    if (tick) begin
                        if (sw_up_over) begin
                            led_next = ~led_reg;
                            if (sweep_tri) begin
                                fword_next = FWORD_MAX;
                                state_next = SWEEP_DOWN;
                            end else begin
                                fword_next = FWORD_MIN;
                            end
                        end else begin
                            fword_next = fword_reg + SWEEP_STEP;
                        end
                    end
                end
            end
            SWEEP_DOWN: begin
                if (!sweep_en) begin
                    state_next = MANUAL;
                    fword_next = man_fw_reg;
                end else begin
                    tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
                    if (tick) begin
                        if (!sweep_tri) begin
                            // Shape changed to sawtooth: resume climbing from here.
                            state_next = SWEEP_UP;
                        end else if (sw_dn_under) begin
                            fword_next = FWORD_MIN;
                            state_next = SWEEP_UP;
                            led_next   = ~led_reg;
                        end else begin
                            fword_next = fword_reg - SWEEP_STEP;
                        end
                    end
                end
            end
            default: begin
                state_next = MANUAL;
                fword_next = man_fw_reg;
            end
        endcase
    end

    // State, frequency word, and change-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= MANUAL;
            man_fw_reg   <= FWORD_INIT;
            fword_reg    <= FWORD_INIT;
            tick_cnt_reg <= '0;
            led_reg      <= 1'b0;
            upd_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            man_fw_reg   <= man_fw_next;
            fword_reg    <= fword_next;
            tick_cnt_reg <= tick_cnt_next;
            led_reg      <= led_next;
            upd_reg      <= (fword_next != fword_reg);
        end
    end

    assign fword        = fword_reg;
    assign fword_upd    = upd_reg;
    assign sweep_active = (state_reg != MANUAL);
    assign LED1         = led_reg;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl with small parameters (DEB=4, DIV=3).
module tb_dds_sweep_ctrl;

    localparam int INIT  = 300;
    localparam int STEP  = 100;
    localparam int MINV  = 100;
    localparam int MAXV  = 500;
    localparam int SSTEP = 100;
    localparam int DIV   = 3;
    localparam int DEB   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_plus = 1'b1;
    logic        key_down = 1'b1;
    logic        sweep_en = 1'b0;
    logic        sweep_tri = 1'b0;
    logic [31:0] fword;
    logic        fword_upd;
    logic        sweep_active;
    logic        LED1;

    int          total = 0;
    int          bad = 0;
    int          exp_man = INIT;
    bit          exp_led = 1'b0;
    int          upd_cnt = 0;
    bit          mon_skip = 1'b1;
    logic [31:0] prev_fw = '0;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(
        .FW_W       (32),
        .FWORD_INIT (32'd300),
        .FWORD_STEP (32'd100),
        .FWORD_MIN  (32'd100),
        .FWORD_MAX  (32'd500),
        .SWEEP_STEP (32'd100),
        .SWEEP_DIV  (DIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_plus     (key_plus),
        .key_down     (key_down),
        .sweep_en     (sweep_en),
        .sweep_tri    (sweep_tri),
        .fword        (fword),
        .fword_upd    (fword_upd),
        .sweep_active (sweep_active),
        .LED1         (LED1)
    );

    // Every cycle: fword_upd must mark exactly the cycles where fword changed,
    // and fword must stay within bounds.
    always @(negedge clk) begin
        if (fword_upd === 1'b1) upd_cnt++;
        if (!mon_skip) begin
            total++;
            if (fword_upd !== (fword != prev_fw)) begin
                bad++;
                $display("FAIL upd_rule: fword_upd=%0b, required %0b (fword %0d prev %0d)",
                         fword_upd, (fword != prev_fw), fword, prev_fw);
            end
            total++;
            if (fword < MINV || fword > MAXV) begin
                bad++;
                $display("FAIL fword_range: fword=%0d, required %0d..%0d", fword, MINV, MAXV);
            end
        end
        prev_fw = fword;
    end

    // Stimulus: press keys (p = plus, d = down) for hold cycles, release for
    // rel cycles, and update the manual-word model. Returns the expected
    // number of fword_upd pulses over the window.
    task automatic press_keys(input bit p, input bit d, input int hold, input int rel,
                              output int exp_pulses);
        int old;
        old = exp_man;
        key_plus = ~p;
        key_down = ~d;
        repeat (hold) @(negedge clk);
        key_plus = 1'b1;
        key_down = 1'b1;
        repeat (rel) @(negedge clk);
        if (p && !d) exp_man = (exp_man + STEP > MAXV) ? MAXV : exp_man + STEP;
        else if (d && !p) exp_man = (exp_man - STEP < MINV) ? MINV : exp_man - STEP;
        exp_pulses = (exp_man != old) ? 1 : 0;
    endtask

    task automatic test_reset;
        mon_skip = 1'b1;
        rst = 1'b1;
        key_plus = 1'b1;
        key_down = 1'b1;
        sweep_en = 1'b0;
        sweep_tri = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (fword !== 32'(INIT)) begin bad++; $display("FAIL reset_fword: got %0d, required %0d", fword, INIT); end
        total++;
        if (fword_upd !== 1'b0) begin bad++; $display("FAIL reset_upd: got %0b, required 0", fword_upd); end
        total++;
        if (sweep_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %0b, required 0", sweep_active); end
        total++;
        if (LED1 !== 1'b0) begin bad++; $display("FAIL reset_led: got %0b, required 0", LED1); end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        mon_skip = 1'b0;
        exp_man = INIT;
        exp_led = 1'b0;
        $display("reset: fword=%0d", fword);
    endtask

    task automatic test_manual_step;
        int ep, c0;
        // single plus press, held 10 cycles
        c0 = upd_cnt;
        press_keys(1, 0, 10, 12, ep);
        total++;
        if (fword !== 32'(exp_man) || exp_man != 400) begin bad++; $display("FAIL plus_first: got %0d, required 400", fword); end
        total++;
        if (upd_cnt - c0 != ep) begin bad++; $display("FAIL plus_first_upd: got %0d pulses, required %0d", upd_cnt - c0, ep); end
        $display("press plus: fword=%0d", fword);
        // short bounce must be rejected
        c0 = upd_cnt;
        key_plus = 1'b0; @(negedge clk);
        key_plus = 1'b1; @(negedge clk);
        key_plus = 1'b0; @(negedge clk);
        key_plus = 1'b1;
        repeat (14) @(negedge clk);
        total++;
        if (fword !== 32'(exp_man) || upd_cnt != c0) begin
            bad++; $display("FAIL bounce: got fword %0d pulses %0d, required %0d pulses 0", fword, upd_cnt - c0, exp_man);
        end
        $display("bounce: fword=%0d", fword);
        // three more pluses reach and clamp at the top
        for (int i = 0; i < 3; i++) begin
            c0 = upd_cnt;
            press_keys(1, 0, 9, 10, ep);
            total++;
            if (fword !== 32'(exp_man)) begin bad++; $display("FAIL plus_clamp%0d: got %0d, required %0d", i, fword, exp_man); end
            total++;
            if (upd_cnt - c0 != ep) begin bad++; $display("FAIL plus_clamp_upd%0d: got %0d pulses, required %0d", i, upd_cnt - c0, ep); end
            $display("press plus: fword=%0d", fword);
        end
        // six downs walk to the bottom and clamp
        for (int i = 0; i < 6; i++) begin
            c0 = upd_cnt;
            press_keys(0, 1, 9, 10, ep);
            total++;
            if (fword !== 32'(exp_man)) begin bad++; $display("FAIL down%0d: got %0d, required %0d", i, fword, exp_man); end
            total++;
            if (upd_cnt - c0 != ep) begin bad++; $display("FAIL down_upd%0d: got %0d pulses, required %0d", i, upd_cnt - c0, ep); end
            $display("press down: fword=%0d", fword);
        end
    endtask

    task automatic test_both_keys;
        int ep, c0;
        press_keys(1, 0, 9, 10, ep);
        c0 = upd_cnt;
        press_keys(1, 1, 10, 10, ep);
        total++;
        if (fword !== 32'(exp_man) || exp_man != 200) begin bad++; $display("FAIL both_keys: got %0d, required 200", fword); end
        total++;
        if (upd_cnt != c0) begin bad++; $display("FAIL both_keys_upd: got %0d pulses, required 0", upd_cnt - c0); end
        $display("press both: fword=%0d", fword);
    endtask

    // Run a sweep for nticks ticks from entry, checking every cycle against the
    // sweep rules, then leave the sweep exit_off cycles after the last tick.
    task automatic run_sweep(input bit tri_mode, input int nticks, input int exit_off, input bit key_during);
        int  fw;
        bit  up;
        sweep_tri = tri_mode;
        sweep_en  = 1'b1;
        fw = MINV;
        up = 1'b1;
        @(negedge clk);
        for (int k = 0; k < nticks; k++) begin
            if (key_during && k == 1) key_plus = 1'b0;
            if (key_during && k == 4) key_plus = 1'b1;
            for (int c = 0; c < DIV; c++) begin
                total++;
                if (fword !== 32'(fw)) begin bad++; $display("FAIL sweep_fword t%0d c%0d: got %0d, required %0d", k, c, fword, fw); end
                total++;
                if (LED1 !== exp_led) begin bad++; $display("FAIL sweep_led t%0d: got %0b, required %0b", k, LED1, exp_led); end
                total++;
                if (sweep_active !== 1'b1) begin bad++; $display("FAIL sweep_active t%0d: got %0b, required 1", k, sweep_active); end
                @(negedge clk);
            end
            if (up) begin
                if (fw + SSTEP > MAXV) begin
                    exp_led = ~exp_led;
                    if (tri_mode) begin fw = MAXV; up = 1'b0; end
                    else fw = MINV;
                end else fw = fw + SSTEP;
            end else begin
                if (fw - SSTEP < MINV) begin fw = MINV; up = 1'b1; exp_led = ~exp_led; end
                else fw = fw - SSTEP;
            end
        end
        for (int c = 0; c < exit_off; c++) begin
            total++;
            if (fword !== 32'(fw)) begin bad++; $display("FAIL sweep_tail c%0d: got %0d, required %0d", c, fword, fw); end
            @(negedge clk);
        end
        sweep_en = 1'b0;
        @(negedge clk);
        total++;
        if (fword !== 32'(exp_man)) begin bad++; $display("FAIL sweep_exit: got %0d, required %0d", fword, exp_man); end
        total++;
        if (sweep_active !== 1'b0) begin bad++; $display("FAIL sweep_exit_active: got %0b, required 0", sweep_active); end
        repeat (12) @(negedge clk);
        total++;
        if (fword !== 32'(exp_man)) begin bad++; $display("FAIL sweep_after: got %0d, required %0d", fword, exp_man); end
        $display("sweep tri=%0b ticks=%0d: exit fword=%0d led=%0b", tri_mode, nticks, fword, LED1);
    endtask

    task automatic test_sweep_saw;
        run_sweep(1'b0, 6, 1, 1'b0);
    endtask

    task automatic test_sweep_tri;
        run_sweep(1'b1, 11, 2, 1'b1);
    endtask

    task automatic test_reset_mid_sweep;
        int ep, c0;
        sweep_tri = 1'b0;
        sweep_en  = 1'b1;
        repeat (16) @(negedge clk);
        key_plus = 1'b0;
        repeat (2) @(negedge clk);
        mon_skip = 1'b1;
        rst = 1'b1;
        sweep_en = 1'b0;
        @(negedge clk);
        total++;
        if (fword !== 32'(INIT)) begin bad++; $display("FAIL rst_mid_fword: got %0d, required %0d", fword, INIT); end
        total++;
        if (sweep_active !== 1'b0 || LED1 !== 1'b0) begin
            bad++; $display("FAIL rst_mid_state: active=%0b led=%0b, required 0 0", sweep_active, LED1);
        end
        rst = 1'b0;
        exp_man = INIT;
        exp_led = 1'b0;
        repeat (2) @(negedge clk);
        mon_skip = 1'b0;
        c0 = upd_cnt;
        repeat (18) @(negedge clk);
        key_plus = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (fword !== 32'(INIT) || upd_cnt != c0) begin
            bad++; $display("FAIL held_key: got fword %0d pulses %0d, required %0d pulses 0", fword, upd_cnt - c0, INIT);
        end
        press_keys(1, 0, 9, 10, ep);
        total++;
        if (fword !== 32'(exp_man) || exp_man != 400) begin bad++; $display("FAIL repress: got %0d, required 400", fword); end
        $display("reset mid-sweep: fword=%0d", fword);
    endtask

    task automatic test_random;
        int ep, c0, r, n;
        for (int round = 0; round < 6; round++) begin
            n = $urandom_range(2, 5);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                if (r < 9 && $urandom_range(0, 1) == 1) begin
                    if (r < 5) key_plus = 1'b0; else key_down = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    key_plus = 1'b1;
                    key_down = 1'b1;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                c0 = upd_cnt;
                press_keys(r < 5 || r == 9, r >= 5, $urandom_range(8, 14), $urandom_range(8, 14), ep);
                total++;
                if (fword !== 32'(exp_man)) begin bad++; $display("FAIL rand_press r%0d i%0d: got %0d, required %0d", round, i, fword, exp_man); end
                total++;
                if (upd_cnt - c0 != ep) begin bad++; $display("FAIL rand_upd r%0d i%0d: got %0d pulses, required %0d", round, i, upd_cnt - c0, ep); end
                $display("random press kind=%0d: fword=%0d", r, fword);
            end
            run_sweep(1'($urandom_range(0, 1)), $urandom_range(3, 14), $urandom_range(0, DIV - 1), 1'b0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_manual_step();
        test_both_keys();
        test_sweep_saw();
        test_sweep_tri();
        test_reset_mid_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
